acc_cpu_ctrl: RTL and testbench
===============================

Name: acc_cpu_ctrl

Overview:
Multi-cycle fetch/decode/execute controller for the 16-bit accumulator CPU. It is the bus initiator for the instruction memory (read-only, combinational) and the data memory (combinational read, level-sensitive write). It owns PC, IR and AC, and drives all memory address and strobe lines from registers so the level-sensitive data-memory write never sees glitches.

Parameters:
ADDR_W, 13, width of PC, instruction address bus and data address bus
DATA_W, 16, width of instruction word, AC and data bus
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  system clock; rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  resume pulse; honoured only in HALT
im_abus  out  ADDR_W  instruction address (registered, equals PC)
im_dbus  in  DATA_W  instruction word from instruction memory
dm_rd  out  1  data-memory read strobe (registered)
dm_wr  out  1  data-memory write strobe (registered)
dm_abus  out  ADDR_W  data address (registered)
dm_wdata  out  DATA_W  write data (registered)
dm_rdata  in  DATA_W  read data from data memory
pc  out  ADDR_W  current PC
ac  out  DATA_W  accumulator
halted  out  1  high while in HALT

Behaviour:
- Instruction format: opcode = instr[15:13], operand = instr[12:0]. 000 LDA, 001 STA, 010 ADD, 011 SUB, 100 JMP, 101 JEZ, 110 LDI, 111 HLT.
- Reset (async, immediate): state=FETCH, PC=RESET_PC, IR=0, AC=0, dm_rd=0, dm_wr=0, dm_abus=0, dm_wdata=0, halted=0. Strobes drop combinationally with rst; no write may complete after rst rises.
- States: FETCH -> DECODE -> EXEC -> FETCH. HLT goes DECODE -> HALT. Every non-halt instruction takes exactly 3 cycles.
- FETCH: im_abus=PC. At the clock edge: IR<=im_dbus, PC<=PC+1 (mod 2^ADDR_W; 8191 wraps to 0).
- DECODE: at the clock edge, dm_abus<=IR[12:0]. dm_rd<=1 for LDA/ADD/SUB. For STA, dm_wr<=1 and dm_wdata<=AC. Strobes for every other opcode stay 0.
- EXEC, at the clock edge:
  - LDA: AC<=dm_rdata.
  - ADD: AC<=AC+dm_rdata. SUB: AC<=AC-dm_rdata. Both wrap mod 2^16; no carry or overflow flag.
  - STA: no register change; the write occurs while dm_wr is high.
  - JMP: PC<=IR[12:0].
  - JEZ: PC<=IR[12:0] if AC==0, else PC unchanged.
  - LDI: AC<={3'b000, IR[12:0]} (zero-extended).
  - In all cases dm_rd<=0 and dm_wr<=0, so each strobe is high for exactly the EXEC cycle.
- dm_abus and dm_wdata hold their values until the next DECODE. They never change while dm_wr=1.
- HALT: halted=1, strobes 0, PC holds (points past the HLT).
  - start=1 sampled at a clock edge -> FETCH; halted clears on that edge.
  - start in any other state is ignored.
  - start held high across a HALT entry resumes on the first edge in HALT.
- Undefined memory contents (X) propagate into IR/AC; no special handling.

Test Plan:
- Program {0000,4001,2002,6003,A007,0,0,C00B,2004,E000,8000}, dm[0..4]={5,1,0,6,0}, release reset -> dm[2]=6, AC=0 after SUB, JEZ to 7, AC=0x000B, dm[4]=0x000B. halted rises exactly 24 cycles after reset release with PC=10.
- After the halt above, hold start=0 for 10 cycles (PC, AC, strobes stable). Then pulse start 1 cycle -> JMP 0 executes, PC=0, and the program repeats. dm[2] is again 6.
- JEZ not taken: AC=1, instr A005 at PC=3 -> PC=4 after EXEC.
- Wrap: AC=0xFFFF, ADD of dm value 1 -> AC=0x0000, then JEZ taken. PC at 0x1FFF fetch -> PC=0x0000.
- Assert rst during the EXEC cycle of STA -> dm_wr falls the same delta as rst, the target location is unchanged afterwards, and all outputs are at reset values.
- Each of dm_rd/dm_wr is high for exactly 1 cycle per LDA/ADD/SUB/STA and never for JMP/JEZ/LDI/HLT. dm_abus/dm_wdata are stable throughout the high period.

Source files
------------

// File: rtl/acc_cpu_ctrl.sv
// Fetch/decode/execute controller for the 16-bit accumulator CPU.
// Owns PC, IR and AC; every memory address and strobe comes straight from a register.
module acc_cpu_ctrl #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] im_abus,
  input  logic [DATA_W-1:0] im_dbus,
  output logic              dm_rd,
  output logic              dm_wr,
  output logic [ADDR_W-1:0] dm_abus,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ac,
  output logic              halted
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_HALT   = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    OP_LDA = 3'b000,
    OP_STA = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_JMP = 3'b100,
    OP_JEZ = 3'b101,
    OP_LDI = 3'b110,
    OP_HLT = 3'b111
  } opcode_t;

  state_t            state;
  state_t            state_next;
  logic [DATA_W-1:0] ir;
  opcode_t           opcode;
  logic [ADDR_W-1:0] operand;

  assign opcode  = opcode_t'(ir[DATA_W-1 -: 3]);
  assign operand = ir[ADDR_W-1:0];
  assign im_abus = pc;
  assign halted  = (state == S_HALT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: state_next = (opcode == OP_HLT) ? S_HALT : S_EXEC;
      S_EXEC:   state_next = S_FETCH;
      S_HALT:   if (start) state_next = S_FETCH;
      default:  state_next = S_FETCH;
    endcase
  end

  // Strobes are set in DECODE and cleared in EXEC, so each is high for exactly the EXEC cycle
  // while dm_abus/dm_wdata (only loaded in DECODE) stay put underneath them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      ir       <= '0;
      ac       <= '0;
      dm_rd    <= 1'b0;
      dm_wr    <= 1'b0;
      dm_abus  <= '0;
      dm_wdata <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          ir <= im_dbus;
          pc <= pc + ADDR_W'(1);
        end
        S_DECODE: begin
          dm_abus <= operand;
          dm_rd   <= (opcode == OP_LDA) || (opcode == OP_ADD) || (opcode == OP_SUB);
          if (opcode == OP_STA) begin
            dm_wr    <= 1'b1;
            dm_wdata <= ac;
          end
        end
        S_EXEC: begin
          dm_rd <= 1'b0;
          dm_wr <= 1'b0;
          case (opcode)
            OP_LDA:  ac <= dm_rdata;
            OP_ADD:  ac <= ac + dm_rdata;
            OP_SUB:  ac <= ac - dm_rdata;
            OP_JMP:  pc <= operand;
            OP_JEZ:  if (ac == '0) pc <= operand;
            OP_LDI:  ac <= DATA_W'(operand);
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_cpu_ctrl.sv
// Directed bench for acc_cpu_ctrl: small programs in behavioural instruction/data memories,
// hand-computed AC/PC/timing expectations and a queue of expected data-memory writes.
module tb_acc_cpu_ctrl;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 16;

  logic              clk;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] im_abus;
  logic [DATA_W-1:0] im_dbus;
  logic              dm_rd;
  logic              dm_wr;
  logic [ADDR_W-1:0] dm_abus;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] ac;
  logic              halted;

  logic [DATA_W-1:0] im [2**ADDR_W];
  logic [DATA_W-1:0] dm [2**ADDR_W];

  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0]        ac_log [64];
  logic [ADDR_W-1:0]        pc_log [64];

  int n_checks = 0;
  int n_pass   = 0;
  int rd_cnt   = 0;
  int wr_cnt   = 0;
  int long_cnt = 0;
  logic prev_rd = 1'b0;
  logic prev_wr = 1'b0;

  acc_cpu_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC('0)) dut (
    .clk(clk), .rst(rst), .start(start),
    .im_abus(im_abus), .im_dbus(im_dbus),
    .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_abus(dm_abus), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
    .pc(pc), .ac(ac), .halted(halted)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memories ----------------
  assign im_dbus  = im[im_abus];
  assign dm_rdata = dm[dm_abus];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // A write lands only when the strobe is still high at the edge closing the EXEC cycle.
  always @(posedge clk) begin
    logic [ADDR_W+DATA_W-1:0] exp_w;
    if (dm_wr && !rst) begin
      exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      check("dm_write", {dm_abus, dm_wdata}, 32'(exp_w));
      dm[dm_abus] = dm_wdata;
    end
  end

  // Strobe pulse counting and pulse-length monitor
  always @(negedge clk) begin
    if (dm_rd) begin rd_cnt++; if (prev_rd) long_cnt++; end
    if (dm_wr) begin wr_cnt++; if (prev_wr) long_cnt++; end
    prev_rd = dm_rd;
    prev_wr = dm_wr;
  end

  // ---------------- driver tasks ----------------
  task automatic clear_mem();
    for (int i = 0; i < 2**ADDR_W; i++) begin
      im[i] = 16'hE000;
      dm[i] = 16'h0000;
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic run_to_halt(input int max_cyc, output int n);
    n = 0;
    while (!halted && n < max_cyc) begin
      step(1);
      n++;
      if (n < 64) begin
        ac_log[n] = ac;
        pc_log[n] = pc;
      end
    end
    check("halt_reached", 32'(halted), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pc"},       32'(pc),       32'd0);
    check({tag, "_im_abus"},  32'(im_abus),  32'd0);
    check({tag, "_ac"},       32'(ac),       32'd0);
    check({tag, "_dm_rd"},    32'(dm_rd),    32'd0);
    check({tag, "_dm_wr"},    32'(dm_wr),    32'd0);
    check({tag, "_dm_abus"},  32'(dm_abus),  32'd0);
    check({tag, "_dm_wdata"}, 32'(dm_wdata), 32'd0);
    check({tag, "_halted"},   32'(halted),   32'd0);
  endtask

  task automatic clear_counts();
    rd_cnt = 0;
    wr_cnt = 0;
    long_cnt = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int idle_bad;
    rst = 1'b1;
    start = 1'b0;
    clear_mem();
    step(2);
    check_reset_outputs("rst0");

    // Main program: LDA 0; ADD 1; STA 2; SUB 3; JEZ 7; -; -; LDI 11; STA 4; HLT; JMP 0
    im[0] = 16'h0000; im[1] = 16'h4001; im[2] = 16'h2002; im[3] = 16'h6003;
    im[4] = 16'hA007; im[5] = 16'h0000; im[6] = 16'h0000; im[7] = 16'hC00B;
    im[8] = 16'h2004; im[9] = 16'hE000; im[10] = 16'h8000;
    dm[0] = 16'd5; dm[1] = 16'd1; dm[2] = 16'd0; dm[3] = 16'd6; dm[4] = 16'd0;
    exp_q.push_back({13'd2, 16'h0006});
    exp_q.push_back({13'd4, 16'h000B});
    clear_counts();
    rst = 1'b0;
    run_to_halt(100, n);
    check("p1_ac_lda",    32'(ac_log[3]),  32'h0005);
    check("p1_ac_add",    32'(ac_log[6]),  32'h0006);
    check("p1_ac_sub",    32'(ac_log[12]), 32'h0000);
    check("p1_pc_jez",    32'(pc_log[15]), 32'd7);
    check("p1_ac_ldi",    32'(ac_log[18]), 32'h000B);
    // cycle 1 is the one in which rst falls
    check("p1_halt_cycle", 32'(n + 1),     32'd24);
    check("p1_pc",        32'(pc),         32'd10);
    check("p1_ac",        32'(ac),         32'h000B);
    check("p1_dm2",       32'(dm[2]),      32'h0006);
    check("p1_dm4",       32'(dm[4]),      32'h000B);
    check("p1_rd_pulses", 32'(rd_cnt),     32'd3);
    check("p1_wr_pulses", 32'(wr_cnt),     32'd2);
    check("p1_long",      32'(long_cnt),   32'd0);
    check("p1_wr_pending", 32'(exp_q.size()), 32'd0);

    // Sit in HALT with start low
    idle_bad = 0;
    repeat (10) begin
      step(1);
      if (pc !== 13'd10 || ac !== 16'h000B || dm_rd !== 1'b0 || dm_wr !== 1'b0 || halted !== 1'b1)
        idle_bad++;
    end
    check("halt_idle", 32'(idle_bad), 32'd0);

    // Resume: JMP 0 then the program repeats; start held through FETCH/DECODE is ignored
    dm[2] = 16'd0; dm[4] = 16'd0;
    exp_q.push_back({13'd2, 16'h0006});
    exp_q.push_back({13'd4, 16'h000B});
    clear_counts();
    start = 1'b1;
    step(1);
    check("resume_halted", 32'(halted), 32'd0);
    check("resume_pc",     32'(pc),     32'd10);
    step(2);
    start = 1'b0;
    run_to_halt(100, n);
    check("p2_edges",     32'(n + 2),   32'd26);
    check("p2_pc",        32'(pc),      32'd10);
    check("p2_dm2",       32'(dm[2]),   32'h0006);
    check("p2_dm4",       32'(dm[4]),   32'h000B);
    check("p2_rd_pulses", 32'(rd_cnt),  32'd3);
    check("p2_wr_pulses", 32'(wr_cnt),  32'd2);
    check("p2_wr_pending", 32'(exp_q.size()), 32'd0);

    // JEZ not taken: LDI 1 x3; JEZ 5 at PC=3; HLT at 4
    rst = 1'b1;
    step(1);
    clear_mem();
    im[0] = 16'hC001; im[1] = 16'hC001; im[2] = 16'hC001; im[3] = 16'hA005;
    clear_counts();
    rst = 1'b0;
    run_to_halt(100, n);
    check("jez_nt_pc_exec", 32'(pc_log[12]), 32'd4);
    check("jez_nt_pc",      32'(pc),         32'd5);
    check("jez_nt_ac",      32'(ac),         32'h0001);
    check("jez_nt_edges",   32'(n),          32'd14);
    check("jez_nt_strobes", 32'(rd_cnt + wr_cnt), 32'd0);

    // Wrap: 0xFFFF + 1 = 0, JEZ to 0x1FFF, fetch there wraps PC to 0
    rst = 1'b1;
    step(1);
    clear_mem();
    im[0] = 16'h0000; im[1] = 16'h4001; im[2] = 16'hBFFF; im[13'h1FFF] = 16'hE000;
    dm[0] = 16'hFFFF; dm[1] = 16'h0001;
    rst = 1'b0;
    run_to_halt(100, n);
    check("wrap_ac_lda",   32'(ac_log[3]),  32'h0000FFFF);
    check("wrap_ac_add",   32'(ac_log[6]),  32'h0000);
    check("wrap_pc_jez",   32'(pc_log[9]),  32'h1FFF);
    check("wrap_pc_fetch", 32'(pc_log[10]), 32'h0000);
    check("wrap_pc",       32'(pc),         32'h0000);
    check("wrap_edges",    32'(n),          32'd11);

    // Reset in the EXEC cycle of STA: write must not land
    rst = 1'b1;
    step(1);
    clear_mem();
    im[0] = 16'hC123; im[1] = 16'h2010;
    dm[16] = 16'h5555;
    rst = 1'b0;
    step(5);
    check("sta_exec_wr",    32'(dm_wr),    32'd1);
    check("sta_exec_rd",    32'(dm_rd),    32'd0);
    check("sta_exec_abus",  32'(dm_abus),  32'h0010);
    check("sta_exec_wdata", 32'(dm_wdata), 32'h0123);
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_sta");
    step(2);
    check("rst_sta_dm", 32'(dm[16]), 32'h5555);
    check("rst_sta_wr_pending", 32'(exp_q.size()), 32'd0);

    // start held high from reset release across HALT entry resumes on the first HALT edge
    start = 1'b1;
    exp_q.push_back({13'h0010, 16'h0123});
    rst = 1'b0;
    run_to_halt(100, n);
    check("hold_edges", 32'(n),  32'd8);
    check("hold_pc",    32'(pc), 32'd3);
    step(1);
    check("hold_resume", 32'(halted), 32'd0);
    start = 1'b0;
    run_to_halt(100, n);
    check("hold_edges2", 32'(n),      32'd2);
    check("hold_pc2",    32'(pc),     32'd4);
    check("hold_dm",     32'(dm[16]), 32'h0123);
    check("hold_wr_pending", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
